// File: rtl/axi_lite_mem_responder_if.sv
// AXI4-Lite channel bundle for the memory responder.
// The slave modport is the responder side and the master modport is the requester side.
interface axi_lite_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite word memory that handles one outstanding transaction at a time.
// AW and W are captured independently, and a write takes priority over a read.
module axi_lite_mem_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    axi_lite_mem_responder_if.slave   bus
);
    localparam int                    IDX_W   = $clog2(DEPTH);
    localparam int                    NBYTES  = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRESP = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]              state_reg;
    logic                    aw_held_reg, w_held_reg;
    logic [ADDR_WIDTH-1:0]   awaddr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [NBYTES-1:0]       wstrb_reg;
    logic                    bvalid_reg, rvalid_reg;
    logic [1:0]              bresp_reg, rresp_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    idle, aw_fire, w_fire, ar_fire, wr_go, mem_we;
    logic [ADDR_WIDTH-1:0]   wr_addr, wr_off, rd_off;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [NBYTES-1:0]       wr_strb;
    logic                    wr_borrow, rd_borrow, wr_ok, rd_ok;
    logic [IDX_W-1:0]        wr_idx, rd_idx;

    // Readies depend only on state and capture flags. arready also backs off
    // whenever a write is pending or being offered in the same cycle.
    assign idle        = (state_reg == ST_IDLE) && !reset;
    assign bus.awready = idle && !aw_held_reg;
    assign bus.wready  = idle && !w_held_reg;
    assign bus.arready = idle && !aw_held_reg && !w_held_reg && !bus.awvalid && !bus.wvalid;

    assign aw_fire = bus.awvalid && bus.awready;
    assign w_fire  = bus.wvalid && bus.wready;
    assign ar_fire = bus.arvalid && bus.arready;

    // The write fires on the edge of the later handshake, so use the live bus value if it is not yet held.
    assign wr_go   = idle && (aw_held_reg || aw_fire) && (w_held_reg || w_fire);
    assign wr_addr = aw_held_reg ? awaddr_reg : bus.awaddr;
    assign wr_data = w_held_reg  ? wdata_reg  : bus.wdata;
    assign wr_strb = w_held_reg  ? wstrb_reg  : bus.wstrb;

    // The borrow bit rejects addresses below BASE_ADDR without any wrap-around.
    assign {wr_borrow, wr_off} = {1'b0, wr_addr} - {1'b0, BASE_ADDR};
    assign {rd_borrow, rd_off} = {1'b0, bus.araddr} - {1'b0, BASE_ADDR};
    assign wr_ok  = !wr_borrow && ((wr_off >> 2) < DEPTH_A);
    assign rd_ok  = !rd_borrow && ((rd_off >> 2) < DEPTH_A);
    assign wr_idx = wr_off[IDX_W+1:2];
    assign rd_idx = rd_off[IDX_W+1:2];
    assign mem_we = wr_go && wr_ok;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (wr_go) begin
                        aw_held_reg <= 1'b0;
                        w_held_reg  <= 1'b0;
                        bvalid_reg  <= 1'b1;
                        bresp_reg   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        state_reg   <= ST_WRESP;
                    end else begin
                        if (aw_fire) begin
                            aw_held_reg <= 1'b1;
                            awaddr_reg  <= bus.awaddr;
                        end
                        if (w_fire) begin
                            w_held_reg <= 1'b1;
                            wdata_reg  <= bus.wdata;
                            wstrb_reg  <= bus.wstrb;
                        end
                        if (ar_fire) begin
                            rvalid_reg <= 1'b1;
                            rresp_reg  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                            rdata_reg  <= rd_ok ? mem[rd_idx] : '0;
                            state_reg  <= ST_RDATA;
                        end
                    end
                end
                ST_WRESP: begin
                    if (bus.bready) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (bus.rready) begin
                        rvalid_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.bvalid = bvalid_reg;
    assign bus.bresp  = bresp_reg;
    assign bus.rvalid = rvalid_reg;
    assign bus.rresp  = rresp_reg;
    assign bus.rdata  = rdata_reg;
endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed bench for axi_lite_mem_responder: a table of write/read records with
// hand-computed responses, plus sequences for collisions, back-pressure and reset.
module tb_axi_lite_mem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_lite_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake did not occur within cycle budget (t=%0t)", name, $time);
    endtask

    // lead > 0: W is offered that many cycles before AW; lead < 0: AW leads.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input bit finish_b, output logic [1:0] resp);
        int cyc = 0;
        int aw_start, w_start;
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        @(posedge clk); #1;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = (aw_start == 0);
        bus.wvalid  = (w_start == 0);
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            if (w_done && !aw_done) chk("wready_low_after_w", bus.wready, 0);
            if (aw_done && !w_done) chk("awready_low_after_aw", bus.awready, 0);
            chk("bvalid_low_before_hs", bus.bvalid, 0);
            @(posedge clk); #1;
            cyc++;
            if (aw_fire) begin aw_done = 1; bus.awvalid = 0; end
            if (w_fire)  begin w_done = 1;  bus.wvalid = 0;  end
            if (!aw_done && cyc >= aw_start) bus.awvalid = 1;
            if (!w_done && cyc >= w_start)   bus.wvalid = 1;
        end
        if (!(aw_done && w_done)) begin
            bus.awvalid = 0;
            bus.wvalid  = 0;
            timeout_fail("write_handshake");
            resp = 2'bxx;
            return;
        end
        @(negedge clk);
        chk("bvalid_one_cycle_after_hs", bus.bvalid, 1);
        resp = bus.bresp;
        if (finish_b) begin
            bus.bready = 1;
            @(posedge clk); #1;
            bus.bready = 0;
            @(negedge clk);
            chk("bvalid_cleared_after_b", bus.bvalid, 0);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc = 0;
        bit fired = 0;
        @(posedge clk); #1;
        bus.arvalid = 1;
        bus.araddr  = addr;
        while (!fired && cyc < 40) begin
            @(negedge clk);
            fired = bus.arready;
            @(posedge clk); #1;
            cyc++;
        end
        bus.arvalid = 0;
        if (!fired) begin
            timeout_fail("read_handshake");
            data = 'x;
            resp = 2'bxx;
            return;
        end
        @(negedge clk);
        chk("rvalid_one_cycle_after_ar", bus.rvalid, 1);
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1;
        @(posedge clk); #1;
        bus.rready = 0;
        @(negedge clk);
        chk("rvalid_cleared_after_r", bus.rvalid, 0);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;

        vecs[0]  = '{1, 32'h10,       32'h0000_0100, 4'hF,    0, 2'b00, 32'h0};
        vecs[1]  = '{0, 32'h10,       32'h0,         4'h0,    0, 2'b00, 32'h0000_0100};
        vecs[2]  = '{1, 32'h20,       32'hA5A5_A5A5, 4'hF,    3, 2'b00, 32'h0};
        vecs[3]  = '{0, 32'h20,       32'h0,         4'h0,    0, 2'b00, 32'hA5A5_A5A5};
        vecs[4]  = '{1, 32'h8,        32'hFFFF_FFFF, 4'hF,    0, 2'b00, 32'h0};
        vecs[5]  = '{1, 32'h8,        32'h0000_0000, 4'b0101, 0, 2'b00, 32'h0};
        vecs[6]  = '{0, 32'h8,        32'h0,         4'h0,    0, 2'b00, 32'hFF00_FF00};
        vecs[7]  = '{1, 32'h0,        32'h1234_5678, 4'hF,    0, 2'b00, 32'h0};
        vecs[8]  = '{0, 32'h400,      32'h0,         4'h0,    0, 2'b10, 32'h0};
        vecs[9]  = '{1, 32'h400,      32'hDEAD_BEEF, 4'hF,    0, 2'b10, 32'h0};
        vecs[10] = '{0, 32'h0,        32'h0,         4'h0,    0, 2'b00, 32'h1234_5678};
        vecs[11] = '{1, 32'hC,        32'h1122_3344, 4'hF,    0, 2'b00, 32'h0};
        vecs[12] = '{1, 32'hC,        32'hCAFE_F00D, 4'h0,    0, 2'b00, 32'h0};
        vecs[13] = '{0, 32'hC,        32'h0,         4'h0,    0, 2'b00, 32'h1122_3344};
        vecs[14] = '{1, 32'h3FC,      32'h55AA_00FF, 4'hF,   -2, 2'b00, 32'h0};
        vecs[15] = '{0, 32'h3FE,      32'h0,         4'h0,    0, 2'b00, 32'h55AA_00FF};
        vecs[16] = '{0, 32'hFFFF_FFFC, 32'h0,        4'h0,    0, 2'b10, 32'h0};
        vecs[17] = '{0, 32'h3FC,      32'h0,         4'h0,    0, 2'b00, 32'h55AA_00FF};

        bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
        reset = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_awready", bus.awready, 0);
        chk("reset_wready",  bus.wready,  0);
        chk("reset_arready", bus.arready, 0);
        chk("reset_bvalid",  bus.bvalid,  0);
        chk("reset_rvalid",  bus.rvalid,  0);
        chk("reset_bresp",   bus.bresp,   0);
        chk("reset_rresp",   bus.rresp,   0);
        chk("reset_rdata",   bus.rdata,   0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("idle_awready", bus.awready, 1);
        chk("idle_arready", bus.arready, 1);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead, 1'b1, resp);
                chk($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
                $display("txn %0d WR addr=%h data=%h strb=%b lead=%0d bresp=%b", i,
                         vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead, resp);
            end else begin
                axi_read(vecs[i].addr, rd, resp);
                chk($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
                $display("txn %0d RD addr=%h rdata=%h rresp=%b", i, vecs[i].addr, rd, resp);
            end
        end

        // Read and write offered together; write wins, B is stalled while AR waits.
        @(posedge clk); #1;
        bus.awvalid = 1; bus.awaddr = 32'h50; bus.wvalid = 1; bus.wdata = 32'h5050_5050; bus.wstrb = 4'hF;
        bus.arvalid = 1; bus.araddr = 32'h50;
        @(negedge clk);
        chk("collide_arready", bus.arready, 0);
        chk("collide_awready", bus.awready, 1);
        chk("collide_wready",  bus.wready,  1);
        @(posedge clk); #1;
        bus.awvalid = 0; bus.wvalid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_bvalid",  bus.bvalid,  1);
            chk("stall_bresp",   bus.bresp,   0);
            chk("stall_arready", bus.arready, 0);
            @(posedge clk); #1;
        end
        bus.bready = 1;
        @(posedge clk); #1;
        bus.bready = 0;
        @(negedge clk);
        chk("post_b_bvalid",  bus.bvalid,  0);
        chk("post_b_arready", bus.arready, 1);
        @(posedge clk); #1;
        bus.arvalid = 0;
        @(negedge clk);
        chk("post_b_rvalid", bus.rvalid, 1);
        chk("post_b_rdata",  bus.rdata,  32'h5050_5050);
        chk("post_b_rresp",  bus.rresp,  0);
        bus.rready = 1;
        @(posedge clk); #1;
        bus.rready = 0;
        $display("txn collide WR+RD addr=00000050 rdata=%h", bus.rdata);

        // Reset while the B response is pending.
        axi_write(32'h60, 32'h0000_0066, 4'hF, 0, 1'b0, resp);
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        chk("rst_wresp_awready", bus.awready, 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("rst_wresp_bvalid",  bus.bvalid,  0);
        chk("rst_wresp_rvalid",  bus.rvalid,  0);
        chk("rst_wresp_awready", bus.awready, 1);
        chk("rst_wresp_wready",  bus.wready,  1);
        $display("txn reset during WRESP");

        // A captured AW is abandoned by reset: a lone W afterwards must not complete.
        @(posedge clk); #1;
        bus.awvalid = 1; bus.awaddr = 32'h70;
        @(negedge clk);
        chk("abandon_awready", bus.awready, 1);
        @(posedge clk); #1;
        bus.awvalid = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        bus.wvalid = 1; bus.wdata = 32'h0000_0077; bus.wstrb = 4'hF;
        @(negedge clk);
        chk("abandon_wready", bus.wready, 1);
        @(posedge clk); #1;
        bus.wvalid = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abandon_no_bvalid", bus.bvalid, 0);
            @(posedge clk); #1;
        end
        bus.awvalid = 1; bus.awaddr = 32'h74;
        @(posedge clk); #1;
        bus.awvalid = 0;
        @(negedge clk);
        chk("abandon_late_aw_bvalid", bus.bvalid, 1);
        bus.bready = 1;
        @(posedge clk); #1;
        bus.bready = 0;
        $display("txn abandoned AW then W+AW to 00000074");

        axi_read(32'h74, rd, resp);
        chk("after_reset_rdata_74", rd, 32'h0000_0077);
        chk("after_reset_rresp_74", resp, 0);
        $display("txn RD addr=00000074 rdata=%h rresp=%b", rd, resp);
        axi_read(32'h80, rd, resp);
        chk("untouched_rresp", resp, 0);
        $display("txn RD addr=00000080 rresp=%b", resp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_lite_mem_responder.md
AXI_LITE_MEM_RESPONDER -- requirements
Module: axi_lite_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning AXI-Lite address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning data width; only 32 is supported.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning number of 32-bit words; must be a power of two.
REQ-004 The block SHALL have parameter BASE_ADDR, default 32'h0, meaning byte address of word 0.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port awvalid, input, 1 bit: write address valid.
REQ-008 The block SHALL have port awready, output, 1 bit: write address ready.
REQ-009 The block SHALL have port awaddr, input, ADDR_WIDTH bits: write byte address.
REQ-010 The block SHALL have port wvalid, input, 1 bit: write data valid.
REQ-011 The block SHALL have port wready, output, 1 bit: write data ready.
REQ-012 The block SHALL have port wdata, input, 32 bits: write data.
REQ-013 The block SHALL have port wstrb, input, 4 bits: byte enables.
REQ-014 The block SHALL have port bvalid, output, 1 bit: write response valid.
REQ-015 The block SHALL have port bready, input, 1 bit: write response ready.
REQ-016 The block SHALL have port bresp, output, 2 bits: write response, OKAY=00 or SLVERR=10.
REQ-017 The block SHALL have port arvalid, input, 1 bit: read address valid.
REQ-018 The block SHALL have port arready, output, 1 bit: read address ready.
REQ-019 The block SHALL have port araddr, input, ADDR_WIDTH bits: read byte address.
REQ-020 The block SHALL have port rvalid, output, 1 bit: read data valid.
REQ-021 The block SHALL have port rready, input, 1 bit: read data ready.
REQ-022 The block SHALL have port rdata, output, 32 bits: read data.
REQ-023 The block SHALL have port rresp, output, 2 bits: read response, OKAY=00 or SLVERR=10.

Function
REQ-024 The block SHALL implement an FSM with states IDLE, WRESP and RDATA, and SHALL allow one outstanding transaction at a time.
REQ-025 In IDLE, awready SHALL be 1 until AW is captured and wready SHALL be 1 until W is captured; AW and W are captured independently, in either order or in the same cycle.
REQ-026 On the edge where both AW and W are held, the block SHALL perform the write, clear both capture flags, set bvalid=1 and enter WRESP, so bvalid rises 1 cycle after the later of the two handshakes.
REQ-027 In WRESP, bvalid and bresp SHALL be held stable until bready=1; on the edge where bready=1 the block SHALL clear bvalid and return to IDLE.
REQ-028 arready SHALL be 1 only in IDLE with no AW or W captured and awvalid=0 and wvalid=0, so a write wins when a read and a write arrive in the same cycle.
REQ-029 On an AR handshake the block SHALL load rdata and rresp, set rvalid=1 one cycle later and enter RDATA.
REQ-030 In RDATA, rvalid, rdata and rresp SHALL be held stable until rready=1, then the block SHALL clear rvalid and return to IDLE.
REQ-031 The word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] are ignored.
REQ-032 An address is in range iff addr >= BASE_ADDR and index < DEPTH, with the comparison done at ADDR_WIDTH with no wrap-around.
REQ-033 An in-range write SHALL update only the bytes whose wstrb bit is 1 and respond bresp=00; wstrb=0000 is a legal no-op with OKAY.
REQ-034 An out-of-range write SHALL leave memory unchanged and respond bresp=10.
REQ-035 An in-range read SHALL return the stored word with rresp=00; an out-of-range read SHALL return rdata=0 with rresp=10.
REQ-036 A read issued after a completed write (B handshake done) SHALL return the written data.
REQ-037 All ready outputs SHALL depend only on state and capture flags, never combinationally on input valids, except arready per REQ-028.

Reset
REQ-038 While reset=1, the block SHALL force awready=wready=arready=bvalid=rvalid=0, bresp=rresp=00, rdata=0, state=IDLE and clear the capture flags; memory contents are not reset, and reset mid-transaction SHALL abandon that transaction without completing the write or sending any response.

Verification
REQ-039 Scenario: AW+W same cycle to 0x10 with wdata=0x100 and wstrb=F, then AR to 0x10 -> bvalid 1 cycle after the handshake with bresp=00; rdata=0x100 with rresp=00.
REQ-040 Scenario: W 3 cycles before AW to 0x20 with data 0xA5A5A5A5 -> wready drops after W, bvalid 1 cycle after AW, and a readback returns 0xA5A5A5A5.
REQ-041 Scenario: write 0xFFFFFFFF to 0x8, then write 0x00000000 with wstrb=0101 -> readback 0xFF00FF00.
REQ-042 Scenario: AR to BASE_ADDR+4*DEPTH and a write there -> rresp=10 with rdata=0; bresp=10; word 0 unchanged.
REQ-043 Scenario: bready held 0 for 5 cycles, with AR asserted meanwhile -> bvalid stable, arready=0 until the B handshake, then the read completes.
REQ-044 Scenario: reset asserted while in WRESP -> next cycle all valids=0 and state=IDLE; a subsequent read of an untouched location completes with OKAY.
